// File: rtl/cp0_pkg.sv
// CP0 register numbers, field positions and exception codes
// shared by the coprocessor-0 unit and its request arbiter.
package cp0_pkg;

  localparam logic [4:0] CP0_SR    = 5'd12;
  localparam logic [4:0] CP0_CAUSE = 5'd13;
  localparam logic [4:0] CP0_EPC   = 5'd14;
  localparam logic [4:0] CP0_PRID  = 5'd15;

  localparam int SR_IE     = 0;
  localparam int SR_EXL    = 1;
  localparam int SR_IM_LO  = 10;
  localparam int SR_IM_HI  = 15;

  localparam int CA_EXC_LO = 2;
  localparam int CA_EXC_HI = 6;
  localparam int CA_IP_LO  = 10;
  localparam int CA_IP_HI  = 15;
  localparam int CA_BD     = 31;

  localparam logic [31:0] PRID_VAL = 32'h2023_0007;

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_SYS  = 5'd8,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_e;

  function automatic logic [31:0] pack_sr(
    input logic [5:0] im,
    input logic       exl,
    input logic       ie
  );
    logic [31:0] v;
    v = '0;
    v[SR_IM_HI:SR_IM_LO] = im;
    v[SR_EXL] = exl;
    v[SR_IE]  = ie;
    return v;
  endfunction

  function automatic logic [31:0] pack_cause(
    input logic       bd,
    input logic [5:0] ip,
    input logic [4:0] exc
  );
    logic [31:0] v;
    v = '0;
    v[CA_BD] = bd;
    v[CA_IP_HI:CA_IP_LO]   = ip;
    v[CA_EXC_HI:CA_EXC_LO] = exc;
    return v;
  endfunction

endpackage

// File: rtl/cp0_req_arb.sv
// Combinational exception/interrupt arbiter: decides whether the
// M-stage instruction traps this cycle and which ExcCode is logged.
module cp0_req_arb
  import cp0_pkg::*;
(
  input  logic [5:0] i_hw_int,
  input  logic [5:0] i_sr_im,
  input  logic       i_sr_ie,
  input  logic       i_sr_exl,
  input  logic [4:0] i_exc_code,
  output logic       o_int_req,
  output logic       o_exc_req,
  output logic       o_req,
  output logic [4:0] o_exc_code
);

  logic w_int_pend;

  assign w_int_pend = |(i_hw_int & i_sr_im);
  assign o_int_req  = w_int_pend & i_sr_ie & ~i_sr_exl;
  assign o_exc_req  = (i_exc_code != 5'd0) & ~i_sr_exl;
  assign o_req      = o_int_req | o_exc_req;

  // interrupts win over any synchronous exception in the same slot
  assign o_exc_code = o_int_req ? EXC_INT : i_exc_code;

endmodule

// File: rtl/cp0_unit.sv
// Coprocessor 0: SR/Cause/EPC/PRId, trap entry, eret and mtc0/mfc0
// for the M stage; raises req to flush the pipeline on a trap.
module cp0_unit
  import cp0_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic [31:0] vpc,
  input  logic        bd_in,
  input  logic [4:0]  exc_code_in,
  input  logic        eret,
  input  logic [5:0]  hw_int,
  output logic        req,
  output logic [31:0] epc_out
);

  logic [5:0]  r_sr_im;
  logic        r_sr_exl;
  logic        r_sr_ie;
  logic        r_cause_bd;
  logic [5:0]  r_cause_ip;
  logic [4:0]  r_cause_exc;
  logic [31:0] r_epc;

  logic        w_int_req;
  logic        w_exc_req;
  logic        w_req;
  logic [4:0]  w_exc_code;
  logic [31:0] w_vpc_al;
  logic [31:0] w_epc_trap;
  logic        w_wr_sr;
  logic        w_wr_epc;

  cp0_req_arb u_arb (
    .i_hw_int   (hw_int),
    .i_sr_im    (r_sr_im),
    .i_sr_ie    (r_sr_ie),
    .i_sr_exl   (r_sr_exl),
    .i_exc_code (exc_code_in),
    .o_int_req  (w_int_req),
    .o_exc_req  (w_exc_req),
    .o_req      (w_req),
    .o_exc_code (w_exc_code)
  );

  assign req = w_req;

  // a delay-slot trap restarts at the branch itself
  assign w_vpc_al   = vpc & ~32'h3;
  assign w_epc_trap = bd_in ? (w_vpc_al - 32'd4)
                            : w_vpc_al;

  assign w_wr_sr  = we & (addr == CP0_SR);
  assign w_wr_epc = we & (addr == CP0_EPC);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sr_im     <= '0;
      r_sr_exl    <= 1'b0;
      r_sr_ie     <= 1'b0;
      r_cause_bd  <= 1'b0;
      r_cause_ip  <= '0;
      r_cause_exc <= '0;
      r_epc       <= '0;
    end else begin
      r_cause_ip <= hw_int;
      if (w_req) begin
        r_sr_exl    <= 1'b1;
        r_cause_exc <= w_exc_code;
        r_cause_bd  <= bd_in;
        r_epc       <= w_epc_trap;
      end else begin
        if (w_wr_sr) begin
          r_sr_im <= wdata[SR_IM_HI:SR_IM_LO];
          r_sr_ie <= wdata[SR_IE];
        end
        if (w_wr_epc) r_epc <= wdata;
        if (eret)         r_sr_exl <= 1'b0;
        else if (w_wr_sr) r_sr_exl <= wdata[SR_EXL];
      end
    end
  end

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      addr == CP0_SR:
        rdata = pack_sr(r_sr_im, r_sr_exl, r_sr_ie);
      addr == CP0_CAUSE:
        rdata = pack_cause(r_cause_bd, r_cause_ip,
                           r_cause_exc);
      addr == CP0_EPC:  rdata = r_epc;
      addr == CP0_PRID: rdata = PRID_VAL;
      default:          rdata = '0;
    endcase
  end

  // eret in the slot right after mtc0 EPC sees the new value
  assign epc_out = (w_wr_epc & ~w_req) ? wdata : r_epc;

  logic w_unused;
  assign w_unused = w_exc_req;

endmodule

// File: doc/cp0_unit.md
CP0_UNIT -- requirements
Module: cp0_unit

Interface
REQ-001 SHALL have ports: clk  in  1  clock, all state updates on rising edge.
REQ-002 SHALL have ports: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: we  in  1  mtc0 write enable, driven from M-stage CP0_WE.
REQ-004 SHALL have ports: addr  in  5  CP0 register number, read and write, driven from M-stage RD_Addr.
REQ-005 SHALL have ports: wdata  in  32  mtc0 data, the forwarded M-stage RT.
REQ-006 SHALL have ports: rdata  out  32  mfc0 read data, combinational.
REQ-007 SHALL have ports: vpc  in  32  PC of the M-stage instruction.
REQ-008 SHALL have ports: bd_in  in  1  M-stage instruction is in a branch delay slot.
REQ-009 SHALL have ports: exc_code_in  in  5  merged M-stage exception code, 0 = none.
REQ-010 SHALL have ports: eret  in  1  M-stage instruction is eret.
REQ-011 SHALL have ports: hw_int  in  6  external interrupt lines, level-sensitive.
REQ-012 SHALL have ports: req  out  1  take-exception request, which flushes all pipeline registers.
REQ-013 SHALL have ports: epc_out  out  32  return address for eret.

Function
REQ-014 SHALL implement SR (12): IM[15:10], EXL[1], IE[0]; all other bits read 0.
REQ-015 SHALL implement Cause (13): BD[31], IP[15:10], ExcCode[6:2]; all other bits read 0.
REQ-016 SHALL implement EPC (14) as full 32 bits, and PRId (15) as constant 32'h2023_0007.
REQ-017 SHALL return 0 on rdata for every other addr.
REQ-018 SHALL compute int_req = (|(hw_int & SR.IM)) & SR.IE & ~SR.EXL, combinationally from the current cycle.
REQ-019 SHALL compute exc_req = (exc_code_in != 0) & ~SR.EXL.
REQ-020 SHALL drive req = int_req | exc_req in the same cycle, with no register.
REQ-021 SHALL give interrupts priority: when int_req=1, Cause.ExcCode <= 0 regardless of exc_code_in.
REQ-022 SHALL, at the edge where req=1: set SR.EXL <= 1, set Cause.ExcCode <= (int_req ? 0 : exc_code_in), set Cause.BD <= bd_in, and set EPC <= bd_in ? {vpc[31:2],2'b00}-4 : {vpc[31:2],2'b00}.
REQ-023 SHALL update Cause.IP <= hw_int every cycle, unconditionally, regardless of req or we.
REQ-024 SHALL make mtc0 to SR write only IM, EXL and IE; Cause SHALL be read-only to mtc0.
REQ-025 SHALL make mtc0 to EPC write all 32 bits.
REQ-026 SHALL make mtc0 to PRId a no-op.
REQ-027 SHALL ignore we when req=1, because the faulting instruction does not commit.
REQ-028 SHALL clear SR.EXL at the edge where eret=1 and req=0.
REQ-029 SHALL ignore eret when req=1.
REQ-030 SHALL drive epc_out = wdata when we=1, addr=14 and req=0 (same-cycle bypass); otherwise epc_out = EPC.
REQ-031 SHALL suppress any further req while EXL=1, for both nested exceptions and interrupts.
REQ-032 SHALL clear EXL with mtc0 SR in the same way as eret.
REQ-033 SHALL make rdata reflect pre-edge register state, with no bypass of a same-cycle write.

Reset
REQ-034 SHALL, on rst at a clock edge, clear SR, Cause and EPC to 0; req=0 follows because IE=0.
REQ-035 SHALL give rst priority over req, we and eret in the same cycle.

Structure
REQ-036 SHALL place in package cp0_pkg: register numbers (12–15), SR/Cause bit positions, PRId value, and ExcCode constants: Int=0, AdEL=4, AdES=5, Syscall=8, RI=10, Ov=12.
REQ-037 SHALL use one combinational sub-module, cp0_req_arb, to compute int_req, exc_req, req and the selected ExcCode.
REQ-038 SHALL keep all state in cp0_unit.

Verification
REQ-039 SHALL cover: mtc0 SR=32'h0000_0401, hw_int=6'b000001 -> req=1 the next cycle; Cause.ExcCode=0, EXL=1, EPC=vpc.
REQ-040 SHALL cover: exc_code_in=12, bd_in=1, vpc=32'h0000_3010 -> req=1 same cycle; EPC=32'h0000_300C, Cause=32'h8000_0030.
REQ-041 SHALL cover: EXL=1 with exc_code_in=4 -> req=0 and Cause/EPC unchanged; then eret -> EXL=0.
REQ-042 SHALL cover: int_req and exc_code_in=8 in the same cycle -> ExcCode=0 (interrupt wins).
REQ-043 SHALL cover: we=1, addr=14, wdata=32'h0000_3100 -> epc_out=32'h0000_3100 that cycle; the same write with req=1 leaves EPC unchanged.
REQ-044 SHALL cover: rst asserted during a pending interrupt -> SR/Cause/EPC=0 and req=0 the next cycle.
